// File: rtl/dmem_sram_like_bridge_pkg.sv
// Shared types and constants for the data-memory SRAM-like bridge.
//   state_e       : bridge FSM states
//   SizeB/H/W     : bus data_size encodings (byte, half, word)
package dmem_sram_like_bridge_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,  // no outstanding transfer
      StWaitAddr = 2'd1,  // request issued, not yet accepted
      StWaitData = 2'd2,  // accepted, awaiting data_ok
      StDone     = 2'd3   // finished, pipeline still frozen externally
   } state_e;

   localparam logic [1:0] SizeB = 2'd0;
   localparam logic [1:0] SizeH = 2'd1;
   localparam logic [1:0] SizeW = 2'd2;

endpackage

// File: rtl/dmem_sram_like_bridge_if.sv
// SRAM-like bus between the data-memory bridge and the cache/AXI side.
//   master : bridge side (drives req/wr/size/addr/wdata)
//   slave  : bus side (drives rdata/addr_ok/data_ok)
interface dmem_sram_like_bridge_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();

   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic [DATA_W-1:0] data_rdata;
   logic              data_addr_ok;
   logic              data_data_ok;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_rdata, data_addr_ok, data_data_ok
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_rdata, data_addr_ok, data_data_ok
   );

endinterface

// File: rtl/dmem_size_decode.sv
// Byte-enable decoder: derives bus write flag and transfer size from wen.
//   i_wen  : byte write enables (0 = read)
//   o_wr   : 1 when any byte enable is set
//   o_size : 0 byte, 1 half, 2 word; reads use READ_SIZE, odd patterns use word
module dmem_size_decode
   import dmem_sram_like_bridge_pkg::*;
#(
   parameter logic [1:0] READ_SIZE = SizeW
) (
   input  logic [3:0] i_wen,
   output logic       o_wr,
   output logic [1:0] o_size
);

   always_comb begin
      o_wr   = |i_wen;
      o_size = SizeW;
      case (i_wen)
         4'b0000:                            o_size = READ_SIZE;
         4'b1111:                            o_size = SizeW;
         4'b0011, 4'b1100:                   o_size = SizeH;
         4'b0001, 4'b0010, 4'b0100, 4'b1000: o_size = SizeB;
         default:                            o_size = SizeW;
      endcase
   end

endmodule

// File: rtl/dmem_sram_like_bridge.sv
// M-stage data-memory port to SRAM-like bus bridge.
// Turns the single-cycle SRAM-style request into a req/addr_ok/data_ok handshake,
// stalls the pipeline until completion and holds read data for the W stage.
// Optional counters enabled by defining DMEM_BRIDGE_PERF_EN.
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_cpu_en/wen/addr/wdata : M-stage access (wen == 0 is a read)
//   i_ext_stall          : pipeline frozen by another source
//   o_cpu_stall          : freeze request to the hazard unit
//   o_cpu_rdata          : registered read data
//   io_bus               : SRAM-like bus (master side)
//   o_perf_req_cnt       : accepted requests (0 when counters disabled)
//   o_perf_stall_cnt     : stalled cycles (0 when counters disabled)
module dmem_sram_like_bridge
   import dmem_sram_like_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter logic [1:0]  READ_SIZE = SizeW
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_cpu_en,
   input  logic [3:0]              i_cpu_wen,
   input  logic [ADDR_W-1:0]       i_cpu_addr,
   input  logic [DATA_W-1:0]       i_cpu_wdata,
   input  logic                    i_ext_stall,
   output logic                    o_cpu_stall,
   output logic [DATA_W-1:0]       o_cpu_rdata,
   dmem_sram_like_bridge_if.master io_bus,
   output logic [31:0]             o_perf_req_cnt,
   output logic [31:0]             o_perf_stall_cnt
);

   state_e            r_state;
   state_e            w_state_d;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [3:0]        r_wen;
   logic [DATA_W-1:0] r_rdata;

   logic              w_idle;
   logic              w_wait_addr;
   logic              w_wait_data;
   logic              w_done;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic [3:0]        w_wen;
   logic              w_wr;
   logic [1:0]        w_size;
   logic              w_req;
   logic              w_accept;
   logic              w_complete;
   logic              w_stall;

   assign w_idle      = (r_state == StIdle);
   assign w_wait_addr = (r_state == StWaitAddr);
   assign w_wait_data = (r_state == StWaitData);
   assign w_done      = (r_state == StDone);

   // IDLE drives the bus straight from the core for zero-latency issue.
   assign w_addr  = w_idle ? i_cpu_addr  : r_addr;
   assign w_wdata = w_idle ? i_cpu_wdata : r_wdata;
   assign w_wen   = w_idle ? i_cpu_wen   : r_wen;

   dmem_size_decode #(
      .READ_SIZE (READ_SIZE)
   ) u_size_decode (
      .i_wen  (w_wen),
      .o_wr   (w_wr),
      .o_size (w_size)
   );

   // Reset gates the combinational outputs so nothing leaks while rst is low.
   assign w_req      = i_rst_n & ((w_idle & i_cpu_en) | w_wait_addr);
   assign w_accept   = w_req & io_bus.data_addr_ok;
   assign w_complete = (w_accept & io_bus.data_data_ok) | (w_wait_data & io_bus.data_data_ok);
   // A dropped cpu_en lets the accepted transfer finish silently.
   assign w_stall    = i_rst_n & i_cpu_en & ~w_done & ~w_complete;

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle, StWaitAddr: begin
            if (w_accept) begin
               if (io_bus.data_data_ok) w_state_d = i_ext_stall ? StDone : StIdle;
               else                     w_state_d = StWaitData;
            end else if (w_req) begin
               w_state_d = StWaitAddr;
            end
         end
         StWaitData: begin
            if (io_bus.data_data_ok) w_state_d = i_ext_stall ? StDone : StIdle;
         end
         StDone: begin
            if (!i_ext_stall) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wen   <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_d;
         if (w_idle && i_cpu_en) begin
            r_addr  <= i_cpu_addr;
            r_wdata <= i_cpu_wdata;
            r_wen   <= i_cpu_wen;
         end
         if (w_complete && !w_wr) r_rdata <= io_bus.data_rdata;
      end
   end

`ifdef DMEM_BRIDGE_PERF_EN
   logic [31:0] r_perf_req_cnt;
   logic [31:0] r_perf_stall_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_perf_req_cnt   <= '0;
         r_perf_stall_cnt <= '0;
      end else begin
         if (w_accept) r_perf_req_cnt   <= r_perf_req_cnt + 32'd1;
         if (w_stall)  r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
   end

   assign o_perf_req_cnt   = r_perf_req_cnt;
   assign o_perf_stall_cnt = r_perf_stall_cnt;
`else
   assign o_perf_req_cnt   = '0;
   assign o_perf_stall_cnt = '0;
`endif

   assign io_bus.data_req   = w_req;
   assign io_bus.data_wr    = w_wr;
   assign io_bus.data_size  = w_size;
   assign io_bus.data_addr  = w_addr;
   assign io_bus.data_wdata = w_wdata;
   assign o_cpu_stall       = w_stall;
   assign o_cpu_rdata       = r_rdata;

endmodule

// File: tb/tb_dmem_sram_like_bridge.sv
// Directed self-checking bench for dmem_sram_like_bridge.
module tb_dmem_sram_like_bridge;

   logic        clk;
   logic        rst_n;
   logic        cpu_en;
   logic [3:0]  cpu_wen;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        ext_stall;
   logic        cpu_stall;
   logic [31:0] cpu_rdata;
   logic [31:0] perf_req_cnt;
   logic [31:0] perf_stall_cnt;

   int n_cmp = 0;
   int n_err = 0;

   dmem_sram_like_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dmem_sram_like_bridge dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_cpu_en         (cpu_en),
      .i_cpu_wen        (cpu_wen),
      .i_cpu_addr       (cpu_addr),
      .i_cpu_wdata      (cpu_wdata),
      .i_ext_stall      (ext_stall),
      .o_cpu_stall      (cpu_stall),
      .o_cpu_rdata      (cpu_rdata),
      .io_bus           (bus),
      .o_perf_req_cnt   (perf_req_cnt),
      .o_perf_stall_cnt (perf_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] tbl_wen  [11] = '{4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010,
                                  4'b0100, 4'b1000, 4'b0110, 4'b0101, 4'b0111};
   logic [1:0] tbl_size [11] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0,
                                  2'd0, 2'd0, 2'd2, 2'd2, 2'd2};

   initial begin
      rst_n            = 1'b0;
      cpu_en           = 1'b1;
      cpu_wen          = 4'b0000;
      cpu_addr         = 32'h0000_0100;
      cpu_wdata        = 32'h0;
      ext_stall        = 1'b0;
      bus.data_rdata   = 32'h0;
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;

      // Reset state, with cpu_en already high to prove outputs are held off.
      #3;
      check_val("rst_req", 32'(bus.data_req), 32'd0);
      check_val("rst_stall", 32'(cpu_stall), 32'd0);
      check_val("rst_rdata", cpu_rdata, 32'h0);
      cpu_en = 1'b0;
      step();
      step();
      rst_n = 1'b1;

      // Size/write decode straight from the core in IDLE.
      for (int i = 0; i < 11; i++) begin
         cpu_wen = tbl_wen[i];
         #2;
         check_val($sformatf("size_%b", tbl_wen[i]), 32'(bus.data_size), 32'(tbl_size[i]));
         check_val($sformatf("wr_%b", tbl_wen[i]), 32'(bus.data_wr), 32'(tbl_wen[i] != 4'b0000));
      end
      check_val("idle_noreq", 32'(bus.data_req), 32'd0);
      step();

      // 1: single-cycle read.
      cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_0100;
      bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEAD_BEEF;
      #2;
      check_val("t1_req", 32'(bus.data_req), 32'd1);
      check_val("t1_stall", 32'(cpu_stall), 32'd0);
      check_val("t1_addr", bus.data_addr, 32'h0000_0100);
      step();
      cpu_en = 1'b0; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
      #2;
      check_val("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
      check_val("t1_req_after", 32'(bus.data_req), 32'd0);
      check_val("t1_state", 32'(dut.r_state), 32'd0);
      step();

      // 2: halfword store, addr_ok 3 cycles after issue, data_ok 2 cycles later.
      cpu_en = 1'b1; cpu_wen = 4'b0011; cpu_addr = 32'h1000_0002; cpu_wdata = 32'h0000_A5A5;
      for (int c = 0; c < 6; c++) begin
         if (c == 1) begin
            cpu_addr = 32'hFFFF_FFF0; cpu_wen = 4'b1111; cpu_wdata = 32'h1234_0000;
         end
         bus.data_addr_ok = (c == 3);
         bus.data_data_ok = (c == 5);
         #2;
         check_val($sformatf("t2_stall_c%0d", c), 32'(cpu_stall), 32'(c < 5));
         check_val($sformatf("t2_req_c%0d", c), 32'(bus.data_req), 32'(c <= 3));
         check_val($sformatf("t2_addr_c%0d", c), bus.data_addr, 32'h1000_0002);
         check_val($sformatf("t2_size_c%0d", c), 32'(bus.data_size), 32'd1);
         check_val($sformatf("t2_wr_c%0d", c), 32'(bus.data_wr), 32'd1);
         check_val($sformatf("t2_wdata_c%0d", c), bus.data_wdata, 32'h0000_A5A5);
         step();
      end
      cpu_en = 1'b0; cpu_wen = 4'b0000;
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
      #2;
      check_val("t2_state", 32'(dut.r_state), 32'd0);
      check_val("t2_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
      step();

      // 3: read completes while ext_stall holds the pipeline.
      cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_0200; ext_stall = 1'b1;
      bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234_5678;
      #2;
      check_val("t3_req", 32'(bus.data_req), 32'd1);
      check_val("t3_stall", 32'(cpu_stall), 32'd0);
      step();
      bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b0; bus.data_rdata = 32'hBAD0_BAD0;
      for (int i = 0; i < 4; i++) begin
         ext_stall = (i < 3);
         #2;
         check_val($sformatf("t3_state_%0d", i), 32'(dut.r_state), 32'd3);
         check_val($sformatf("t3_noreq_%0d", i), 32'(bus.data_req), 32'd0);
         check_val($sformatf("t3_nostall_%0d", i), 32'(cpu_stall), 32'd0);
         check_val($sformatf("t3_rdata_%0d", i), cpu_rdata, 32'h1234_5678);
         step();
      end
      cpu_en = 1'b0; bus.data_addr_ok = 1'b0;
      #2;
      check_val("t3_back_idle", 32'(dut.r_state), 32'd0);
      step();

      // 4: back-to-back reads after a fresh reset so the counters start at zero.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      cpu_en = 1'b1; cpu_addr = 32'h0000_0000;
      bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b0;
      #2;
      check_val("t4_req0", 32'(bus.data_req), 32'd1);
      check_val("t4_addr0", bus.data_addr, 32'h0000_0000);
      check_val("t4_stall0", 32'(cpu_stall), 32'd1);
      step();
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1111_1111;
      #2;
      check_val("t4_stall1", 32'(cpu_stall), 32'd0);
      check_val("t4_noreq1", 32'(bus.data_req), 32'd0);
      step();
      cpu_addr = 32'h0000_0004;
      bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b0;
      #2;
      check_val("t4_rdata0", cpu_rdata, 32'h1111_1111);
      check_val("t4_req2", 32'(bus.data_req), 32'd1);
      check_val("t4_addr2", bus.data_addr, 32'h0000_0004);
      step();
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h2222_2222;
      #2;
      check_val("t4_stall3", 32'(cpu_stall), 32'd0);
      step();
      cpu_en = 1'b0; bus.data_data_ok = 1'b0;
      #2;
      check_val("t4_rdata1", cpu_rdata, 32'h2222_2222);
`ifdef DMEM_BRIDGE_PERF_EN
      check_val("t4_perf_req", perf_req_cnt, 32'd2);
      check_val("t4_perf_stall", perf_stall_cnt, 32'd2);
`else
      check_val("t4_perf_req", perf_req_cnt, 32'd0);
      check_val("t4_perf_stall", perf_stall_cnt, 32'd0);
`endif
      step();

      // 5: reset asserted while waiting for data.
      cpu_en = 1'b1; cpu_addr = 32'h0000_0300;
      bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b0;
      step();
      bus.data_addr_ok = 1'b0;
      #2;
      check_val("t5_wait_data", 32'(dut.r_state), 32'd2);
      check_val("t5_stall", 32'(cpu_stall), 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("t5_rst_req", 32'(bus.data_req), 32'd0);
      check_val("t5_rst_stall", 32'(cpu_stall), 32'd0);
      check_val("t5_rst_rdata", cpu_rdata, 32'h0);
      check_val("t5_rst_state", 32'(dut.r_state), 32'd0);
      step();
      rst_n = 1'b1; cpu_en = 1'b0;
      bus.data_data_ok = 1'b1; bus.data_rdata = 32'h5555_AAAA;
      #2;
      check_val("t5_stray_stall", 32'(cpu_stall), 32'd0);
      step();
      bus.data_data_ok = 1'b0;
      #2;
      check_val("t5_stray_state", 32'(dut.r_state), 32'd0);
      check_val("t5_stray_rdata", cpu_rdata, 32'h0);
      step();

      // 6: cpu_en drops while the request is still unaccepted.
      cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_0400;
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
      #2;
      check_val("t6_stall0", 32'(cpu_stall), 32'd1);
      step();
      cpu_en = 1'b0; cpu_addr = 32'h0;
      #2;
      check_val("t6_req1", 32'(bus.data_req), 32'd1);
      check_val("t6_stall1", 32'(cpu_stall), 32'd0);
      check_val("t6_addr1", bus.data_addr, 32'h0000_0400);
      step();
      bus.data_addr_ok = 1'b1;
      #2;
      check_val("t6_req2", 32'(bus.data_req), 32'd1);
      step();
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hCAFE_F00D;
      #2;
      check_val("t6_state3", 32'(dut.r_state), 32'd2);
      check_val("t6_noreq3", 32'(bus.data_req), 32'd0);
      step();
      bus.data_data_ok = 1'b0;
      #2;
      check_val("t6_rdata", cpu_rdata, 32'hCAFE_F00D);
      check_val("t6_idle", 32'(dut.r_state), 32'd0);
      check_val("t6_stall_end", 32'(cpu_stall), 32'd0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_sram_like_bridge.md
Name: dmem_sram_like_bridge

Overview:
- Sits between the core's M-stage data-memory port and the SRAM-like bus toward the cache/AXI bridge.
- Converts the single-cycle SRAM-style request (en, byte write-enables, addr, wdata) into a req/addr_ok/data_ok handshake.
- Raises a stall to the hazard unit until the access completes, and holds the returned read data stable for the W stage.
- Never issues the same access twice while the pipeline stays frozen by another stall source.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (only 32 supported).
- READ_SIZE, 2, data_size driven for reads (2 = word; byte/half extraction is done downstream).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_en  in  1  M-stage memory access valid.
- cpu_wen  in  4  byte write enables; 0 = read.
- cpu_addr  in  ADDR_W  access address.
- cpu_wdata  in  DATA_W  byte-aligned store data.
- ext_stall  in  1  pipeline frozen by another source (div, ifetch).
- cpu_stall  out  1  to hazard unit; freeze F..M.
- cpu_rdata  out  DATA_W  registered read data, sampled by W stage.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  ADDR_W  bus address.
- data_wdata  out  DATA_W  bus write data.
- data_rdata  in  DATA_W  bus read data, valid with data_ok.
- data_addr_ok  in  1  request accepted this cycle.
- data_data_ok  in  1  transfer complete this cycle.
- perf_req_cnt  out  32  optional counter (see feature).
- perf_stall_cnt  out  32  optional counter (see feature).

Behaviour:
- States:
  - IDLE: no outstanding transfer.
  - WAIT_ADDR: req issued, not yet accepted.
  - WAIT_DATA: accepted, awaiting data_ok.
  - DONE: transfer finished, pipeline still frozen by ext_stall.
- Reset (rst=0, async): state=IDLE, cpu_rdata=0, latched addr/wdata/wen=0, counters=0.
- Outputs during reset: data_req=0, cpu_stall=0.
- data_req = (IDLE & cpu_en) | WAIT_ADDR. Issue is zero-latency, combinational from cpu_en in IDLE.
- In IDLE, data_addr/wdata/wr/size come straight from cpu_*. They are latched on every IDLE cycle with cpu_en. In all other states they come from the latches.
- data_wr = |wen.
- data_size from wen:
  - 1111 -> 2.
  - 0011 or 1100 -> 1.
  - Single bit set -> 0.
  - Read -> READ_SIZE.
  - Any other pattern -> 2.
- data_addr = latched/raw addr, unmodified.
- Transitions:
  - IDLE: cpu_en & addr_ok & data_ok -> (ext_stall ? DONE : IDLE).
  - IDLE: cpu_en & addr_ok & ~data_ok -> WAIT_DATA.
  - IDLE: cpu_en & ~addr_ok -> WAIT_ADDR.
  - WAIT_ADDR: addr_ok & data_ok -> (ext_stall ? DONE : IDLE); addr_ok only -> WAIT_DATA; else stay.
  - WAIT_DATA: data_ok -> (ext_stall ? DONE : IDLE); else stay.
  - DONE: ~ext_stall -> IDLE; no request while in DONE.
- cpu_stall = cpu_en & (IDLE | WAIT_ADDR | WAIT_DATA) & ~completion_this_cycle.
  - completion_this_cycle = data_ok in WAIT_DATA, or addr_ok & data_ok in IDLE/WAIT_ADDR.
  - Stall releases in the same cycle data_ok arrives, so the pipeline advances on that edge.
  - cpu_stall is 0 in DONE.
- cpu_rdata loads data_rdata on the completion edge of a read. Writes leave it unchanged; it holds until the next read completes.
- data_ok without an outstanding request is ignored.
- cpu_en dropping while WAIT_ADDR/WAIT_DATA: the transfer still finishes using the latched values, with cpu_stall=0. A request accepted by the bus is never cancelled.
- Reset asserted mid-transfer: immediate return to IDLE. The bus side is reset by the same rst.

Optional Feature:
- DMEM_BRIDGE_PERF_EN defined:
  - perf_req_cnt increments on each addr_ok handshake (data_req & data_addr_ok).
  - perf_stall_cnt increments each cycle cpu_stall=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Shared package holds:
  - State enum (IDLE=2'd0, WAIT_ADDR=2'd1, WAIT_DATA=2'd2, DONE=2'd3).
  - Size constants SIZE_B=0, SIZE_H=1, SIZE_W=2.
- One natural sub-module: dmem_size_decode (combinational wen -> data_wr, data_size). FSM, latches and counters stay in the top.

Test Plan:
- Read, addr_ok and data_ok in the issue cycle, data_rdata=0xDEADBEEF, ext_stall=0:
  - data_req high one cycle, cpu_stall=0 throughout.
  - cpu_rdata=0xDEADBEEF after the edge; state IDLE.
- Store wen=0011 to 0x1000_0002, addr_ok after 3 cycles, data_ok 2 cycles later:
  - data_size=1, data_wr=1, addr held 0x1000_0002 through WAIT_ADDR.
  - cpu_stall high for 5 cycles, low on the data_ok cycle.
- Read completes while ext_stall=1 for 4 more cycles, cpu_en held:
  - State DONE, zero additional data_req.
  - cpu_rdata stable, cpu_stall=0; returns to IDLE when ext_stall falls.
- Back-to-back reads 0x0 and 0x4, each with 1-cycle data latency:
  - Two requests with addresses in order, cpu_rdata updates per completion.
  - With DMEM_BRIDGE_PERF_EN: perf_req_cnt=2.
- rst low during WAIT_DATA:
  - Outputs go to reset values immediately (data_req=0, cpu_stall=0, cpu_rdata=0).
  - A later data_ok is ignored.
- cpu_en drops in WAIT_ADDR:
  - Transfer still completes with the latched values, cpu_stall=0, ends in IDLE.
